design1_wrapper: RTL and testbench
==================================

# design1_wrapper

Self-contained evaluation harness for approximate PCPI multipliers in the PicoSoC approximation study. It hosts four PCPI multiply lanes (a–d), each running at a different approximation level. An internal 16-bit counter sweeps every 8×8-bit signed operand pair. Lanes accept externally driven instruction words, and results are exposed as observation outputs for waveform or bench checking.

## Interface
Parameters:
- none

Ports:
- clk  in  1  single system clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- pcpi_valid  in  1  PCPI valid, shared by all four lanes; held high for continuous operation
- pcpi_insn_a / _b / _c / _d  in  32 each  instruction word per lane
- rs1_o, rs2_o  out  32 each  operands currently presented to the lanes
- ready_a..ready_d  out  1 each  PCPI ready/wr strobe per lane
- rd_a..rd_d  out  32 each  PCPI result per lane

## Operation
- Operand generator: 16-bit counter `cnt`.
  - Increments by 1 (wrapping 0xFFFF→0x0000) every clock in which pcpi_valid=1; holds otherwise.
  - rs1 = sign-extend(cnt[7:0]); rs2 = sign-extend(cnt[15:8]), both to 32 bits.
  - rs1_o/rs2_o are these combinational values.
- Lane decode: lane accepts when all of the following hold:
  - insn[6:0] = 7'b0001011 (custom-0)
  - insn[31:27] = 0
  - insn[14:12] ≤ 3
  - Otherwise the lane never asserts ready.
  - rs1/rs2/rd fields of insn are ignored.
- Approximation mode m = insn[26:25] (0..3):
  - Each operand has its low 2·m bits forced to 0 before multiplication.
  - m=0 is exact.
- funct3 = insn[14:12] selects the 32-bit result of the 64-bit product:
  - 0 MUL: low 32 bits, signed×signed
  - 1 MULH: high 32 bits, signed×signed
  - 2 MULHSU: high 32 bits, rs1 signed × rs2 unsigned
  - 3 MULHU: high 32 bits, unsigned×unsigned
- All lanes are identical hardware; they differ only through their insn input.

## Timing
- Reset (aresetn=0 at a clock edge): cnt=0, ready_*=0, rd_*=0.
  - Reset mid-sweep restarts the sweep from 0 and discards any in-flight result.
- Pipelined, latency 1:
  - Operands and insn sampled at edge t with pcpi_valid=1 and decode accepted → ready_x=1 and rd_x=result during the cycle after edge t.
  - One result per cycle while valid stays high.
- pcpi_valid falling: ready_* deasserts after the next edge; rd_* holds its last value; cnt freezes.
- Insn change while valid is high: takes effect on the next sampled edge; no flush is required.
- Full sweep of all 65536 operand pairs takes 65536 valid cycles.

## Structure
- Shared package `pcpi_approx_pkg`:
  - CUSTOM0_OPCODE = 7'b0001011
  - funct3 encodings (MUL, MULH, MULHSU, MULHU)
  - mode width = 2
- Sub-module `pcpi_approx_mul`:
  - one lane (decode, operand masking, 33×33 signed multiply, result select, output register)
  - instantiated four times
- Top-level contains the counter, the operand sign extension, and the four lane instances.

## Test plan
- Reset:
  - Hold aresetn=0 for 2 cycles with pcpi_valid=1 → ready_*=0, rd_*=0, rs1_o=rs2_o=0.
  - Release reset → cnt starts at 0.
- Exact MUL, all lanes funct3=0, modes 0/1/2/3:
  - cnt=0x0302 → rd_a=6, rd_b=0, rd_c=0, rd_d=0, one cycle later.
  - cnt=0x7F7F → rd_a=0x3F01, rd_b=0x3C10.
- Negative operands, cnt=0xFFFF (rs1=rs2=-1), mode 0:
  - MUL=0x00000001, MULH=0x00000000, MULHSU=0xFFFFFFFF, MULHU=0xFFFFFFFE.
- Mode masking, cnt=0xFFFF, funct3=0:
  - modes 1/2/3 → rd=0x10, 0x100, 0x1000.
- Handshake:
  - Drop pcpi_valid for 5 cycles → ready_* low after one cycle, cnt unchanged.
  - Reassert → sweep resumes at the frozen cnt.
  - Lane with opcode 7'b0110011 or insn[31:27]≠0 → ready stays 0.
- Wrap and mid-sweep reset:
  - 65536 valid cycles → cnt returns to 0x0000.
  - Assert aresetn=0 at cnt=0x1234 → next cycle cnt=0, ready_*=0.

Source files
------------

// File: rtl/pcpi_approx_pkg.sv
// Shared constants and lane request/response types for the approximate PCPI multiplier harness.
package pcpi_approx_pkg;

    localparam int NUM_LANES = 4;
    localparam int XLEN      = 32;
    localparam int MODE_W    = 2;

    localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3
    } funct3_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } lane_req_t;

    typedef struct packed {
        logic            ready;
        logic [XLEN-1:0] rd;
    } lane_rsp_t;

    function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

endpackage

// File: rtl/pcpi_approx_mul.sv
// One PCPI multiply lane: decode, approximate operand masking, 33x33 signed multiply,
// result select and a single output register stage.
module pcpi_approx_mul
    import pcpi_approx_pkg::*;
(
    input  logic      clk,
    input  logic      aresetn,
    input  lane_req_t req_i,
    output lane_rsp_t rsp_o
);

    logic [2:0]        funct3;
    logic [MODE_W-1:0] mode;
    logic              accept;
    logic              fire;
    logic [XLEN-1:0]   mask;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic signed [32:0] a;
    logic signed [32:0] b;
    logic [63:0]       prod;
    logic              ready_d, ready_q;
    logic [XLEN-1:0]   rd_d, rd_q;
    logic              unused_insn;

    assign funct3 = req_i.insn[14:12];
    assign mode   = req_i.insn[26:25];

    assign accept = (req_i.insn[6:0] == CUSTOM0_OPCODE) &&
                    (req_i.insn[31:27] == 5'd0) && !funct3[2];
    assign fire   = req_i.valid && accept;

    // Mode m clears the low 2*m bits of each operand.
    assign mask = 32'hFFFF_FFFF << {mode, 1'b0};
    assign op1  = req_i.rs1 & mask;
    assign op2  = req_i.rs2 & mask;

    // A 33rd bit carries the sign for signed operands and zero for unsigned ones.
    assign a = {(funct3 != F3_MULHU) & op1[31], op1};
    assign b = {((funct3 == F3_MUL) || (funct3 == F3_MULH)) & op2[31], op2};

    // The low 64 bits of the product are exact for every signedness combination.
    assign prod = 64'(a) * 64'(b);

    assign unused_insn = ^{req_i.insn[24:15], req_i.insn[11:7]};

    always_comb begin
        ready_d = fire;
        rd_d    = rd_q;
        if (fire) begin
            rd_d = (funct3 == F3_MUL) ? prod[31:0] : prod[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ready_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            ready_q <= ready_d;
            rd_q    <= rd_d;
        end
    end

    assign rsp_o = '{ready: ready_q, rd: rd_q};

endmodule

// File: rtl/design1_wrapper.sv
// Evaluation harness: a 16-bit counter sweeps all signed 8x8 operand pairs into four
// identical approximate multiply lanes, each configured only by its instruction word.
module design1_wrapper
    import pcpi_approx_pkg::*;
(
    input  logic        clk,
    input  logic        aresetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn_a,
    input  logic [31:0] pcpi_insn_b,
    input  logic [31:0] pcpi_insn_c,
    input  logic [31:0] pcpi_insn_d,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    output logic        ready_a,
    output logic        ready_b,
    output logic        ready_c,
    output logic        ready_d,
    output logic [31:0] rd_a,
    output logic [31:0] rd_b,
    output logic [31:0] rd_c,
    output logic [31:0] rd_d
);

    logic [15:0] cnt_d, cnt_q;
    logic [NUM_LANES-1:0][XLEN-1:0] insn;
    lane_req_t req [NUM_LANES];
    lane_rsp_t rsp [NUM_LANES];

    always_comb begin
        cnt_d = cnt_q;
        if (pcpi_valid) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rs1_o = sext8(cnt_q[7:0]);
    assign rs2_o = sext8(cnt_q[15:8]);

    assign insn = {pcpi_insn_d, pcpi_insn_c, pcpi_insn_b, pcpi_insn_a};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign req[i] = '{valid: pcpi_valid, insn: insn[i], rs1: rs1_o, rs2: rs2_o};

        pcpi_approx_mul u_lane (
            .clk    (clk),
            .aresetn(aresetn),
            .req_i  (req[i]),
            .rsp_o  (rsp[i])
        );
    end

    assign ready_a = rsp[0].ready;
    assign ready_b = rsp[1].ready;
    assign ready_c = rsp[2].ready;
    assign ready_d = rsp[3].ready;
    assign rd_a    = rsp[0].rd;
    assign rd_b    = rsp[1].rd;
    assign rd_c    = rsp[2].rd;
    assign rd_d    = rsp[3].rd;

endmodule

// File: tb/tb_design1_wrapper.sv
// Scoreboard bench: a reference model queues expected lane results at each sampling edge,
// a monitor pops and compares them whenever the DUT presents its outputs.
module tb_design1_wrapper;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        pcpi_valid;
    logic [31:0] insn [4];
    logic [31:0] rs1_o, rs2_o;
    logic        ready_a, ready_b, ready_c, ready_d;
    logic [31:0] rd_a, rd_b, rd_c, rd_d;

    logic [3:0]  rdy;
    logic [31:0] rdv [4];

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    logic [15:0] cnt_m = 16'd0;
    logic [31:0] expq [4][$];
    logic [31:0] held [4];

    always #5 clk = ~clk;

    design1_wrapper dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn_a(insn[0]),
        .pcpi_insn_b(insn[1]),
        .pcpi_insn_c(insn[2]),
        .pcpi_insn_d(insn[3]),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o),
        .ready_a    (ready_a),
        .ready_b    (ready_b),
        .ready_c    (ready_c),
        .ready_d    (ready_d),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .rd_c       (rd_c),
        .rd_d       (rd_d)
    );

    assign rdy     = {ready_d, ready_c, ready_b, ready_a};
    assign rdv[0]  = rd_a;
    assign rdv[1]  = rd_b;
    assign rdv[2]  = rd_c;
    assign rdv[3]  = rd_d;

    function automatic logic [31:0] sx(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    function automatic bit acc(input logic [31:0] ins);
        return (ins[6:0] == 7'b0001011) && (ins[31:27] == 5'd0) && (ins[14:12] <= 3'd3);
    endfunction

    // Expected result from the arithmetic definition of each funct3 on masked operands.
    function automatic logic [31:0] ref_rd(input logic [31:0] ins, input logic [15:0] c);
        logic [31:0] m, x, y;
        longint sp;
        longint unsigned up;
        int sh;
        sh = 2 * int'(ins[26:25]);
        m  = 32'hFFFF_FFFF << sh;
        x  = sx(c[7:0]) & m;
        y  = sx(c[15:8]) & m;
        case (ins[14:12])
            3'd0: begin sp = longint'($signed(x)) * longint'($signed(y)); return sp[31:0]; end
            3'd1: begin sp = longint'($signed(x)) * longint'($signed(y)); return sp[63:32]; end
            3'd2: begin sp = longint'($signed(x)) * longint'({32'd0, y}); return sp[63:32]; end
            default: begin up = {32'd0, x} * {32'd0, y}; return up[63:32]; end
        endcase
    endfunction

    function automatic logic [31:0] mk(input int f3, input int md);
        logic [31:0] r;
        r        = $urandom;
        r[6:0]   = 7'b0001011;
        r[14:12] = f3[2:0];
        r[26:25] = md[1:0];
        r[31:27] = 5'd0;
        return r;
    endfunction

    function automatic logic [31:0] rnd_insn();
        logic [31:0] r;
        int k, u;
        r = mk($urandom_range(0, 7), $urandom_range(0, 3));
        k = $urandom_range(0, 5);
        u = $urandom_range(1, 31);
        if (k == 0) r[6:0] = 7'b0110011;
        if (k == 1) r[31:27] = u[4:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic goto(input logic [15:0] t);
        int n;
        n = 0;
        pcpi_valid = 1'b1;
        while (cnt_m != t && n < 70000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cnt_m != t) begin
            fails++;
            $display("FAIL goto: counter model at %h, target %h not reached", cnt_m, t);
        end
    endtask

    // Reference model: one expected result per accepting lane per valid edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!aresetn) begin
                cnt_m = 16'd0;
                for (int l = 0; l < 4; l++) begin
                    expq[l].delete();
                    held[l] = 32'd0;
                end
            end else if (pcpi_valid) begin
                for (int l = 0; l < 4; l++) begin
                    if (acc(insn[l])) expq[l].push_back(ref_rd(insn[l], cnt_m));
                end
                cnt_m = cnt_m + 16'd1;
            end
        end
    end

    // Monitor: operands every cycle, ready against queue occupancy, rd popped or held.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("rs1_o", rs1_o, sx(cnt_m[7:0]));
                chk("rs2_o", rs2_o, sx(cnt_m[15:8]));
                for (int l = 0; l < 4; l++) begin
                    logic er;
                    logic [31:0] e;
                    er = (expq[l].size() != 0);
                    chk($sformatf("ready[%0d]", l), {31'd0, rdy[l]}, {31'd0, er});
                    if (er) begin
                        e = expq[l].pop_front();
                        if (rdy[l]) begin
                            held[l] = e;
                            chk($sformatf("rd[%0d] cnt=%h", l, cnt_m - 16'd1), rdv[l], e);
                        end
                    end else begin
                        chk($sformatf("rd_hold[%0d]", l), rdv[l], held[l]);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] c0;
        aresetn    = 1'b0;
        pcpi_valid = 1'b1;
        for (int l = 0; l < 4; l++) insn[l] = mk(0, l);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("rst_ready[%0d]", l), {31'd0, rdy[l]}, 32'd0);
            chk($sformatf("rst_rd[%0d]", l), rdv[l], 32'd0);
        end
        chk("rst_rs1", rs1_o, 32'd0);
        chk("rst_rs2", rs2_o, 32'd0);
        mon_en  = 1'b1;
        aresetn = 1'b1;

        // Rejected encodings: wrong opcode, nonzero insn[31:27].
        insn[2]        = mk(0, 1);
        insn[2][6:0]   = 7'b0110011;
        insn[3]        = mk(1, 0);
        insn[3][31:27] = 5'b00001;
        repeat (10) begin
            @(negedge clk);
            chk("bad_opcode_ready", {31'd0, ready_c}, 32'd0);
            chk("bad_upper_ready", {31'd0, ready_d}, 32'd0);
        end

        repeat (200) begin
            @(negedge clk);
            pcpi_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) insn[$urandom_range(0, 3)] = rnd_insn();
        end

        for (int l = 0; l < 4; l++) insn[l] = mk($urandom_range(0, 3), l);
        @(negedge clk);
        pcpi_valid = 1'b1;
        @(negedge clk);
        c0 = cnt_m;
        pcpi_valid = 1'b0;
        @(negedge clk);
        chk("drop_ready", {28'd0, rdy}, 32'd0);
        repeat (4) @(negedge clk);
        chk("frozen_rs1", rs1_o, sx(c0[7:0]));
        chk("frozen_rs2", rs2_o, sx(c0[15:8]));
        pcpi_valid = 1'b1;
        @(negedge clk);
        chk("resume_rs1", rs1_o, sx(c0[7:0] + 8'd1));

        for (int l = 0; l < 4; l++) insn[l] = mk(0, l);
        goto(16'h0302);
        @(negedge clk);
        chk("mul302_a", rd_a, 32'd6);
        chk("mul302_b", rd_b, 32'd0);
        chk("mul302_c", rd_c, 32'd0);
        chk("mul302_d", rd_d, 32'd0);

        goto(16'h1234);
        aresetn = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {28'd0, rdy}, 32'd0);
        chk("midrst_rs1", rs1_o, 32'd0);
        chk("midrst_rs2", rs2_o, 32'd0);
        aresetn = 1'b1;

        goto(16'h7F7F);
        @(negedge clk);
        chk("mul7f_a", rd_a, 32'h3F01);
        chk("mul7f_b", rd_b, 32'h3C10);
        chk("mul7f_c", rd_c, 32'h3100);
        chk("mul7f_d", rd_d, 32'h1000);

        for (int l = 0; l < 4; l++) insn[l] = mk(l, 0);
        goto(16'hFEFF);
        @(negedge clk);
        chk("neg_mul", rd_a, 32'h0000_0002);
        chk("neg_mulh", rd_b, 32'h0000_0000);
        chk("neg_mulhsu", rd_c, 32'hFFFF_FFFF);
        chk("neg_mulhu", rd_d, 32'hFFFF_FFFD);

        for (int l = 0; l < 4; l++) insn[l] = mk(0, l);
        goto(16'hFFFF);
        @(negedge clk);
        chk("mask_m0", rd_a, 32'h0000_0001);
        chk("mask_m1", rd_b, 32'h0000_0010);
        chk("mask_m2", rd_c, 32'h0000_0100);
        chk("mask_m3", rd_d, 32'h0000_1000);
        chk("wrap_rs1", rs1_o, 32'd0);
        chk("wrap_rs2", rs2_o, 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
